// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-bit iterative multiply/divide, one radix-2 step per clock edge.
// Optional macro MULDIV_DIV_EN adds the restoring-divide datapath (DIVU/DIV).
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_p;
    logic [31:0] r_opb;
    logic [31:0] r_p_hi;
    logic [31:0] r_p_lo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_dbz;
`ifdef MULDIV_DIV_EN
    logic        r_neg_r;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_diff;
`endif

    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_prod;
    logic [63:0] w_prod_fix;

    // Signed ops iterate on magnitudes; the sign is restored in FIX.
    always_comb begin
        w_mag_a = (op[0] && a[31]) ? -a : a;
        w_mag_b = (op[0] && b[31]) ? -b : b;
    end

    always_comb begin
        w_mul_sum  = {1'b0, r_p_hi} + (r_p_lo[0] ? {1'b0, r_opb} : 33'd0);
        w_prod     = {r_p_hi, r_p_lo};
        w_prod_fix = r_neg_p ? -w_prod : w_prod;
    end

`ifdef MULDIV_DIV_EN
    always_comb begin
        w_div_shift = {r_p_hi, r_p_lo[31]};
        w_div_diff  = w_div_shift - {1'b0, r_opb};
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_p  <= 1'b0;
            r_opb    <= '0;
            r_p_hi   <= '0;
            r_p_lo   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_neg_r  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_div <= op[1];
                        r_neg_p  <= op[0] & (a[31] ^ b[31]);
`ifdef MULDIV_DIV_EN
                        r_neg_r  <= op[0] & a[31];
`endif
                        r_opb    <= w_mag_b;
                        r_p_lo   <= w_mag_a;
                        r_p_hi   <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_is_div) begin
`ifdef MULDIV_DIV_EN
                        if (r_opb == '0) begin
                            // Re-signing the captured magnitude reproduces the original a.
                            r_hi    <= r_neg_r ? -r_p_lo : r_p_lo;
                            r_lo    <= '1;
                            r_dbz   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            if (!w_div_diff[32]) begin
                                r_p_hi <= w_div_diff[31:0];
                                r_p_lo <= {r_p_lo[30:0], 1'b1};
                            end else begin
                                r_p_hi <= w_div_shift[31:0];
                                r_p_lo <= {r_p_lo[30:0], 1'b0};
                            end
                            r_cnt <= r_cnt + 6'd1;
                            if (r_cnt == 6'd31) r_state <= S_FIX;
                        end
`else
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
`endif
                    end else begin
                        {r_p_hi, r_p_lo} <= {w_mul_sum, r_p_lo[31:1]};
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
`ifdef MULDIV_DIV_EN
                    if (r_is_div) begin
                        r_lo <= r_neg_p ? -r_p_lo : r_p_lo;
                        r_hi <= r_neg_r ? -r_p_hi : r_p_hi;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
`else
                    {r_hi, r_lo} <= w_prod_fix;
`endif
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit; reference results come from 64-bit integer arithmetic.
// Follows the DUT build: define MULDIV_DIV_EN for both to exercise division.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                  output logic [31:0] rh, output logic [31:0] rl,
                                  output logic rdbz, output int rlat);
        longint unsigned ua, ub, up;
        longint sa, sb, sp, sq, sr;
        rdbz = 1'b0;
        rlat = 33;
        rh   = m_hi;
        rl   = m_lo;
        ua   = {32'd0, ma};
        ub   = {32'd0, mb};
        sa   = $signed(ma);
        sb   = $signed(mb);
        case (mop)
            2'b00: begin
                up = ua * ub;
                rh = up[63:32];
                rl = up[31:0];
            end
            2'b01: begin
                sp = sa * sb;
                rh = sp[63:32];
                rl = sp[31:0];
            end
            default: begin
`ifdef MULDIV_DIV_EN
                if (mb == 32'd0) begin
                    rh   = ma;
                    rl   = 32'hFFFF_FFFF;
                    rdbz = 1'b1;
                    rlat = 1;
                end else if (!mop[0]) begin
                    rl = ma / mb;
                    rh = ma % mb;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    rl = sq[31:0];
                    rh = sr[31:0];
                end
`else
                rlat = 1;
`endif
            end
        endcase
    endfunction

    // Caller is just past a negedge; returns just past a negedge with the DUT idle.
    task automatic run_op(input string name, input logic [1:0] top, input logic [31:0] ta, input logic [31:0] tb_v);
        logic [31:0] eh, el;
        logic        edbz;
        int          elat;
        int          n;
        bit          stray_dbz;
        model(top, ta, tb_v, eh, el, edbz, elat);
        start = 1'b1; op = top; a = ta; b = tb_v;
        @(posedge clk);
        #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        n = 0;
        stray_dbz = 1'b0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) break;
            if (div_by_zero !== 1'b0) stray_dbz = 1'b1;
            if (busy !== 1'b1) stray_dbz = 1'b1;
        end
        checks++;
        if (n !== elat) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, expected %0d", name, n, elat);
        end
        checks++;
        if (stray_dbz) begin
            errors++;
            $display("FAIL %s busy/div_by_zero before done: got flag set, expected busy=1 dbz=0", name);
        end
        checks++;
        if (hi !== eh || lo !== el || div_by_zero !== edbz) begin
            errors++;
            $display("FAIL %s result: got hi=%h lo=%h dbz=%b, expected hi=%h lo=%h dbz=%b",
                     name, hi, lo, div_by_zero, eh, el, edbz);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b0 || hi !== eh || lo !== el) begin
            errors++;
            $display("FAIL %s after done: got done=%b busy=%b dbz=%b hi=%h lo=%h, expected 0 0 0 %h %h",
                     name, done, busy, div_by_zero, hi, lo, eh, el);
        end
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        start = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset async: got busy=%b done=%b dbz=%b hi=%h lo=%h, expected all 0",
                     busy, done, div_by_zero, hi, lo);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset hold: got busy=%b, expected 0 while rst high", busy);
        end
        rst   = 1'b0;
        start = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
    endtask

    task automatic test_directed();
        run_op("multu_max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_neg",   2'b01, 32'hFFFF_FFFD, 32'h0000_0007);
        run_op("div_neg",    2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op("divu_100_7", 2'b10, 32'd100,       32'd7);
        run_op("div_ovf",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_zero",  2'b10, 32'h1234_5678, 32'd0);
        run_op("div_zero",   2'b11, 32'h8765_4321, 32'd0);
        run_op("mult_minmin", 2'b01, 32'h8000_0000, 32'h8000_0000);
    endtask

    task automatic test_random();
        logic [31:0] corner [6];
        logic [31:0] ra, rb;
        corner[0] = 32'd0;
        corner[1] = 32'd1;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;
        corner[5] = 32'd3;
        for (int i = 0; i < 24; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, 31);
            run_op($sformatf("rand%0d", i), 2'($urandom), ra, rb);
        end
    endtask

    task automatic test_abort();
        int stray;
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL abort async: got busy=%b done=%b hi=%h lo=%h, expected 0 0 0 0", busy, done, hi, lo);
        end
        #1 rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL abort quiet: got %0d cycles with activity/result, expected 0", stray);
        end
        run_op("abort_restart", 2'b00, 32'd5, 32'd6);
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        int   pulses;
        start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 39) start = 1'b0;
            exp_done = (i == 33) || (i == 68);
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL b2b done at edge %0d: got %b, expected %b", i, done, exp_done);
            end
            if (done === 1'b1) begin
                pulses++;
                checks++;
                if (lo !== 32'd6 || hi !== 32'd0) begin
                    errors++;
                    $display("FAIL b2b result: got hi=%h lo=%h, expected 0 6", hi, lo);
                end
            end
            if (i == 34 || i == 35) begin
                checks++;
                if (busy !== (i == 35)) begin
                    errors++;
                    $display("FAIL b2b busy at edge %0d: got %b, expected %b", i, busy, (i == 35));
                end
            end
        end
        checks++;
        if (pulses !== 2) begin
            errors++;
            $display("FAIL b2b pulse count: got %0d, expected 2", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: none; datapath width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 a  input  32  operand A (register-file rd1); dividend for DIV ops.
REQ-007 b  input  32  operand B (register-file rd2); divisor for DIV ops.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse; hi/lo valid and stable from this cycle onward.
REQ-010 hi  output  32  MULT: product[63:32]; DIV: remainder.
REQ-011 lo  output  32  MULT: product[31:0]; DIV: quotient.
REQ-012 div_by_zero  output  1  high together with done when a DIV/DIVU had b==0.

Function
REQ-013 FSM states IDLE, CALC, FIX, DONE; DONE always returns to IDLE on the next edge.
REQ-014 IDLE with start=1 at edge E0: capture op, |a|, |b| (magnitudes for signed ops; raw for unsigned), result signs, clear 6-bit iteration counter; go to CALC.
REQ-015 CALC: one radix-2 step per edge (shift-add multiply / restoring divide); exactly 32 edges E1..E32; then go to FIX.
REQ-016 FIX (edge E33): apply sign correction, load hi/lo, go to DONE; done=1 for exactly the cycle after E33; at E34 return to IDLE.
REQ-017 Latency: done asserted 33 edges after the start edge; earliest next start is accepted at E35.
REQ-018 start while busy (including during DONE) is ignored; a, b, op may change freely once E0 has passed.
REQ-019 MULT sign: 64-bit product negated (two's complement) when sign(a) xor sign(b).
REQ-020 DIV sign: quotient negated when sign(a) xor sign(b); remainder takes sign(a).
REQ-021 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no flag).
REQ-022 DIV/DIVU with b==0: skip CALC/FIX; E1 goes directly to DONE with hi=a, lo=0xFFFFFFFF, div_by_zero=1.
REQ-023 div_by_zero is 0 in every cycle other than a divide-by-zero DONE cycle.
REQ-024 hi/lo hold their last values between operations; only FIX or divide-by-zero DONE entry updates them.

Reset
REQ-025 rst=1 immediately forces state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0, independent of clk.
REQ-026 rst during CALC/FIX/DONE aborts the operation; no partial result reaches hi/lo.
REQ-027 First start is honoured on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro MULDIV_DIV_EN: when defined, division datapath present and REQ-020..REQ-022 apply.
REQ-029 Without MULDIV_DIV_EN: op 10/11 accepted, E1 goes directly to DONE, hi/lo unchanged, div_by_zero=0; multiply behaviour identical.

Verification
REQ-030 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done 33 edges after start, hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 MULT a=0xFFFFFFFD (-3) b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
REQ-032 DIV a=0xFFFFFFF9 (-7) b=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100/7 -> lo=14, hi=2.
REQ-033 DIVU a=0x12345678 b=0 -> done after E1, div_by_zero=1, hi=0x12345678, lo=0xFFFFFFFF; without macro -> done after E1, hi/lo unchanged, flag 0.
REQ-034 MULTU 5*6 started, rst pulsed at edge E10 -> busy=0, hi=lo=0 asynchronously, no done; restart 5*6 -> lo=30.
REQ-035 start held high for 40 cycles with MULTU 2*3 -> exactly two operations complete (E0 and E35), each done one cycle wide, lo=6.
